// File: rtl/adma_defs.sv
// Shared encodings for the ADMA2 sequencer: FSM states, descriptor actions
// and the bit layout of the 96-bit descriptor.
package adma_defs;

    // State codes double as the adma_err_state encoding.
    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_FDS  = 2'b01,
        ST_CADR = 2'b10,
        ST_TFR  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_t;

    localparam int DESC_W        = 96;
    localparam int DESC_VALID    = 0;
    localparam int DESC_END      = 1;
    localparam int DESC_INT      = 2;
    localparam int DESC_ACT_LSB  = 4;
    localparam int DESC_LEN_LSB  = 16;
    localparam int DESC_ADDR_LSB = 32;

endpackage

// File: rtl/adma_desc_decode.sv
// Combinational split of a 96-bit ADMA2 descriptor into its fields, with the
// zero-length encoding expanded to a full 2^LEN_W byte count.
module adma_desc_decode
    import adma_defs::*;
#(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic [DESC_W-1:0] descriptor,
    output logic              valid,
    output logic              last,
    output logic              intr,
    output act_t              act,
    output logic [LEN_W:0]    length,
    output logic [ADDR_W-1:0] address
);

    logic [LEN_W-1:0] raw_len;
    logic             unused_bits;

    assign valid   = descriptor[DESC_VALID];
    assign last    = descriptor[DESC_END];
    assign intr    = descriptor[DESC_INT];
    assign act     = act_t'(descriptor[DESC_ACT_LSB +: 2]);
    assign raw_len = descriptor[DESC_LEN_LSB +: LEN_W];
    assign address = descriptor[DESC_ADDR_LSB +: ADDR_W];

    // A zero length field means the maximum transfer, not an empty one.
    assign length  = (raw_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, raw_len};

    // Reserved descriptor bits carry no meaning for the sequencer.
    assign unused_bits = ^{descriptor[15:6], descriptor[3]};

endmodule

// File: rtl/adma_controller.sv
// ADMA2 sequencer: walks the descriptor table, launches data transfers,
// follows links and reports done/int/err pulses to the register block.
module adma_controller
    import adma_defs::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DESC_BYTES = 12,
    parameter int LEN_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              adma_start,
    input  logic [ADDR_W-1:0] adma_sys_addr,
    input  logic              adma_abort,
    output logic              fetch_start,
    output logic [ADDR_W-1:0] fetch_address,
    input  logic              fetch_done,
    input  logic [DESC_W-1:0] descriptor,
    output logic              tfr_start,
    output logic [ADDR_W-1:0] tfr_address,
    output logic [LEN_W:0]    tfr_length,
    input  logic              tfr_done,
    input  logic              tfr_error,
    output logic              busy,
    output logic              adma_done,
    output logic              adma_int,
    output logic              adma_err,
    output logic [1:0]        adma_err_state,
    output logic [ADDR_W-1:0] desc_ptr,
    output state_t            fsm_state
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr_d;
    logic [1:0]        err_state_d;
    logic              latch_desc;

    logic              in_valid, in_last, in_intr;
    act_t              in_act;
    logic [LEN_W:0]    in_len;
    logic [ADDR_W-1:0] in_addr;

    logic              q_last, q_intr;
    act_t              q_act;
    logic [LEN_W:0]    q_len;
    logic [ADDR_W-1:0] q_addr;

    adma_desc_decode #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_decode (
        .descriptor (descriptor),
        .valid      (in_valid),
        .last       (in_last),
        .intr       (in_intr),
        .act        (in_act),
        .length     (in_len),
        .address    (in_addr)
    );

    assign busy      = (state != ST_STOP);
    assign fsm_state = state;

    // Pulses are decided combinationally in the cycle of the event; abort suppresses all of them.
    always_comb begin
        state_d     = state;
        ptr_d       = desc_ptr;
        err_state_d = adma_err_state;
        latch_desc  = 1'b0;
        adma_done   = 1'b0;
        adma_int    = 1'b0;
        adma_err    = 1'b0;
        if (adma_abort) begin
            state_d = ST_STOP;
        end else begin
            case (state)
                ST_STOP: begin
                    if (adma_start) begin
                        ptr_d       = adma_sys_addr;
                        err_state_d = ST_STOP;
                        state_d     = ST_FDS;
                    end
                end
                ST_FDS: begin
                    if (fetch_done) begin
                        latch_desc = 1'b1;
                        if (!in_valid) begin
                            adma_err    = 1'b1;
                            err_state_d = ST_FDS;
                            state_d     = ST_STOP;
                        end else begin
                            state_d = ST_CADR;
                        end
                    end
                end
                ST_CADR: begin
                    if (q_act == ACT_TRAN) begin
                        state_d = ST_TFR;
                    end else begin
                        ptr_d    = (q_act == ACT_LINK) ? q_addr : desc_ptr + ADDR_W'(DESC_BYTES);
                        adma_int = q_intr;
                        if (q_last) begin
                            adma_done = 1'b1;
                            state_d   = ST_STOP;
                        end else begin
                            state_d = ST_FDS;
                        end
                    end
                end
                ST_TFR: begin
                    if (tfr_error) begin
                        adma_err    = 1'b1;
                        err_state_d = ST_TFR;
                        state_d     = ST_STOP;
                    end else if (tfr_done) begin
                        adma_int = q_intr;
                        ptr_d    = desc_ptr + ADDR_W'(DESC_BYTES);
                        if (q_last) begin
                            adma_done = 1'b1;
                            state_d   = ST_STOP;
                        end else begin
                            state_d = ST_FDS;
                        end
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end
    end

    // Request lines are registered from the next state so they rise on entry and drop on exit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_STOP;
            desc_ptr       <= '0;
            adma_err_state <= '0;
            fetch_start    <= 1'b0;
            fetch_address  <= '0;
            tfr_start      <= 1'b0;
            tfr_address    <= '0;
            tfr_length     <= '0;
            q_last         <= 1'b0;
            q_intr         <= 1'b0;
            q_act          <= ACT_NOP;
            q_len          <= '0;
            q_addr         <= '0;
        end else begin
            state          <= state_d;
            desc_ptr       <= ptr_d;
            adma_err_state <= err_state_d;
            fetch_start    <= (state_d == ST_FDS);
            tfr_start      <= (state_d == ST_TFR);
            if (state_d == ST_FDS) begin
                fetch_address <= ptr_d;
            end
            if (latch_desc) begin
                q_last <= in_last;
                q_intr <= in_intr;
                q_act  <= in_act;
                q_len  <= in_len;
                q_addr <= in_addr;
            end
            if (state == ST_CADR && state_d == ST_TFR) begin
                tfr_address <= q_addr;
                tfr_length  <= q_len;
            end
        end
    end

endmodule

// File: tb/tb_adma_controller.sv
// Bench for adma_controller: acts as fetch unit and transfer engine over a
// descriptor memory and compares against a table-walking reference model.
module tb_adma_controller;
    import adma_defs::*;

    logic          CLK;
    logic          RESET_N;
    logic          adma_start;
    logic [63:0]   adma_sys_addr;
    logic          adma_abort;
    logic          fetch_start;
    logic [63:0]   fetch_address;
    logic          fetch_done;
    logic [95:0]   descriptor;
    logic          tfr_start;
    logic [63:0]   tfr_address;
    logic [16:0]   tfr_length;
    logic          tfr_done;
    logic          tfr_error;
    logic          busy;
    logic          adma_done;
    logic          adma_int;
    logic          adma_err;
    logic [1:0]    adma_err_state;
    logic [63:0]   desc_ptr;
    state_t        fsm_state;

    adma_controller dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .adma_start     (adma_start),
        .adma_sys_addr  (adma_sys_addr),
        .adma_abort     (adma_abort),
        .fetch_start    (fetch_start),
        .fetch_address  (fetch_address),
        .fetch_done     (fetch_done),
        .descriptor     (descriptor),
        .tfr_start      (tfr_start),
        .tfr_address    (tfr_address),
        .tfr_length     (tfr_length),
        .tfr_done       (tfr_done),
        .tfr_error      (tfr_error),
        .busy           (busy),
        .adma_done      (adma_done),
        .adma_int       (adma_int),
        .adma_err       (adma_err),
        .adma_err_state (adma_err_state),
        .desc_ptr       (desc_ptr),
        .fsm_state      (fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [95:0] mem [logic [63:0]];
    logic [80:0] obs_fetch_q[$], obs_tfr_q[$], exp_fetch_q[$], exp_tfr_q[$];
    int          n_int, n_done, n_err, n_burst;
    bit          timed_out;
    int          exp_int, exp_done, exp_err;
    logic [1:0]  exp_err_state;
    logic [63:0] exp_ptr;

    function automatic logic [95:0] mk(input logic [1:0] act, input logic valid, input logic last,
                                       input logic intr, input logic [15:0] len, input logic [63:0] addr);
        return {addr, len, 10'h0, act, 1'b0, intr, last, valid};
    endfunction

    function automatic logic [95:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 96'h0;
    endfunction

    function automatic int qdiff(input logic [80:0] a[$], input logic [80:0] b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : n;
    endfunction

    function automatic logic [80:0] qat(input logic [80:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : '1;
    endfunction

    // Reference: walk the descriptor table as ADMA2 defines it.
    task automatic model_walk(input logic [63:0] base, input int err_at);
        logic [63:0] ptr;
        logic [95:0] d;
        logic [16:0] len;
        int          ntfr;
        exp_fetch_q.delete(); exp_tfr_q.delete();
        exp_int = 0; exp_done = 0; exp_err = 0; exp_err_state = 2'd0;
        ptr = base; ntfr = 0;
        for (int s = 0; s < 64; s++) begin
            exp_fetch_q.push_back({17'h0, ptr});
            d = mem_rd(ptr);
            if (!d[0]) begin exp_err = 1; exp_err_state = 2'd1; break; end
            if (d[5:4] == 2'b10) begin
                len = (d[31:16] == 16'h0) ? 17'd65536 : {1'b0, d[31:16]};
                exp_tfr_q.push_back({d[95:32], len});
                if (ntfr == err_at) begin exp_err = 1; exp_err_state = 2'd3; break; end
                ntfr++;
                ptr = ptr + 64'd12;
            end else if (d[5:4] == 2'b11) begin
                ptr = d[95:32];
            end else begin
                ptr = ptr + 64'd12;
            end
            if (d[2]) exp_int++;
            if (d[1]) begin exp_done = 1; break; end
        end
        exp_ptr = ptr;
    endtask

    task automatic start_dma(input logic [63:0] base);
        @(negedge CLK);
        adma_sys_addr = base;
        adma_start    = 1'b1;
        @(negedge CLK);
        adma_start    = 1'b0;
    endtask

    // Serves fetch and transfer requests with random latency until the DMA goes idle.
    task automatic run_dma(input logic [63:0] base, input int err_at, input bit both, input bit poke);
        int fw, tw, tfr_idx, cyc;
        bit prev_tfr;
        obs_fetch_q.delete(); obs_tfr_q.delete();
        n_int = 0; n_done = 0; n_err = 0; n_burst = 0; timed_out = 0;
        fw = $urandom_range(0, 3); tw = $urandom_range(0, 3); tfr_idx = 0; prev_tfr = 0;
        start_dma(base);
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge CLK);
            fetch_done = 1'b0; tfr_done = 1'b0; tfr_error = 1'b0; adma_start = 1'b0;
            if (!busy) break;
            if (poke && $urandom_range(0, 7) == 0) begin
                adma_start    = 1'b1;
                adma_sys_addr = {$urandom, $urandom};
            end
            if (tfr_start && !prev_tfr) n_burst++;
            prev_tfr = tfr_start;
            if (fetch_start) begin
                if (fw == 0) begin
                    fetch_done = 1'b1;
                    descriptor = mem_rd(fetch_address);
                    obs_fetch_q.push_back({17'h0, fetch_address});
                    fw = $urandom_range(0, 3);
                end else fw--;
            end
            if (tfr_start) begin
                if (tw == 0) begin
                    obs_tfr_q.push_back({tfr_address, tfr_length});
                    if (tfr_idx == err_at) begin
                        tfr_error = 1'b1;
                        tfr_done  = both ? 1'b1 : 1'($urandom_range(0, 1));
                    end else tfr_done = 1'b1;
                    tfr_idx++;
                    tw = $urandom_range(0, 3);
                end else tw--;
            end
            #1;
            if (adma_int)  n_int++;
            if (adma_done) n_done++;
            if (adma_err)  n_err++;
        end
        if (cyc >= 2000) timed_out = 1;
        fetch_done = 1'b0; tfr_done = 1'b0; tfr_error = 1'b0; adma_start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({fetch_start, fetch_address, tfr_start, tfr_address, tfr_length, busy, adma_done, adma_int,
             adma_err, adma_err_state, desc_ptr} !== '0 || fsm_state !== ST_STOP) begin
            errors++; $display("FAIL reset_initial: outputs %h state %0d, required all 0 / ST_STOP",
                {fetch_start, fetch_address, tfr_start, tfr_address, tfr_length, busy, desc_ptr}, fsm_state);
        end
        @(negedge CLK) RESET_N = 1'b1;
        mem.delete();
        mem[64'h7000] = mk(2'b10, 1'b1, 1'b1, 1'b1, 16'h40, 64'hC000);
        start_dma(64'h7000);
        for (int i = 0; i < 20 && !tfr_start; i++) begin
            fetch_done = fetch_start;
            descriptor = mem_rd(fetch_address);
            @(negedge CLK);
        end
        fetch_done = 1'b0;
        checks++;
        if (tfr_start !== 1'b1) begin errors++; $display("FAIL reset_reach_tfr: tfr_start %b required 1", tfr_start); end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if ({fetch_start, fetch_address, tfr_start, tfr_address, tfr_length, busy, adma_done, adma_int,
             adma_err, adma_err_state, desc_ptr} !== '0) begin
            errors++; $display("FAIL reset_mid_tfr_outputs: got %h required 0",
                {fetch_start, fetch_address, tfr_start, tfr_address, tfr_length, busy, desc_ptr});
        end
        checks++;
        if (fsm_state !== ST_STOP) begin errors++; $display("FAIL reset_mid_tfr_state: got %0d required %0d", fsm_state, ST_STOP); end
        @(negedge CLK) RESET_N = 1'b1;
    endtask

    task automatic test_tran_chain();
        int d;
        mem.delete();
        mem[64'h1000] = mk(2'b10, 1'b1, 1'b0, 1'b1, 16'h0200, 64'h8000);
        mem[64'h100C] = mk(2'b10, 1'b1, 1'b1, 1'b0, 16'h0000, 64'h9000);
        model_walk(64'h1000, -1);
        run_dma(64'h1000, -1, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL tran_timeout: busy %b required 0", busy); end
        checks++; d = qdiff(obs_fetch_q, exp_fetch_q);
        if (d != -1) begin errors++; $display("FAIL tran_fetch[%0d]: got %h required %h", d, qat(obs_fetch_q, d), qat(exp_fetch_q, d)); end
        checks++; d = qdiff(obs_tfr_q, exp_tfr_q);
        if (d != -1) begin errors++; $display("FAIL tran_tfr[%0d]: got %h required %h", d, qat(obs_tfr_q, d), qat(exp_tfr_q, d)); end
        checks++; if (qat(obs_tfr_q, 1) !== {64'h9000, 17'h10000}) begin
            errors++; $display("FAIL tran_len_zero: got %h required %h", qat(obs_tfr_q, 1), {64'h9000, 17'h10000}); end
        checks++; if (n_int != exp_int) begin errors++; $display("FAIL tran_int: got %0d required %0d", n_int, exp_int); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL tran_done: got %0d required 1", n_done); end
        checks++; if (n_err != 0) begin errors++; $display("FAIL tran_err: got %0d required 0", n_err); end
        checks++; if (desc_ptr !== exp_ptr) begin errors++; $display("FAIL tran_ptr: got %h required %h", desc_ptr, exp_ptr); end
    endtask

    task automatic test_link_nop();
        int d;
        mem.delete();
        mem[64'h2000] = mk(2'b11, 1'b1, 1'b0, 1'b0, 16'h0, 64'h3000);
        mem[64'h3000] = mk(2'b00, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
        mem[64'h300C] = mk(2'b10, 1'b1, 1'b1, 1'b0, 16'h0040, 64'hA000);
        model_walk(64'h2000, -1);
        run_dma(64'h2000, -1, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL link_timeout: busy %b required 0", busy); end
        checks++; d = qdiff(obs_fetch_q, exp_fetch_q);
        if (d != -1) begin errors++; $display("FAIL link_fetch[%0d]: got %h required %h", d, qat(obs_fetch_q, d), qat(exp_fetch_q, d)); end
        checks++; if (n_burst != 1) begin errors++; $display("FAIL link_bursts: got %0d required 1", n_burst); end
        checks++; d = qdiff(obs_tfr_q, exp_tfr_q);
        if (d != -1) begin errors++; $display("FAIL link_tfr[%0d]: got %h required %h", d, qat(obs_tfr_q, d), qat(exp_tfr_q, d)); end
        checks++; if (n_done != exp_done) begin errors++; $display("FAIL link_done: got %0d required %0d", n_done, exp_done); end
        checks++; if (desc_ptr !== exp_ptr) begin errors++; $display("FAIL link_ptr: got %h required %h", desc_ptr, exp_ptr); end
    endtask

    task automatic test_invalid();
        mem.delete();
        mem[64'h4000] = mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0100, 64'hD000);
        model_walk(64'h4000, -1);
        run_dma(64'h4000, -1, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL invalid_timeout: busy %b required 0", busy); end
        checks++; if (n_err != 1) begin errors++; $display("FAIL invalid_err: got %0d required 1", n_err); end
        checks++; if (adma_err_state !== 2'b01) begin errors++; $display("FAIL invalid_err_state: got %b required 01", adma_err_state); end
        checks++; if (n_burst != 0) begin errors++; $display("FAIL invalid_bursts: got %0d required 0", n_burst); end
        checks++; if (desc_ptr !== 64'h4000) begin errors++; $display("FAIL invalid_ptr: got %h required 4000", desc_ptr); end
        checks++; if (n_done != 0 || n_int != 0) begin errors++; $display("FAIL invalid_pulses: done %0d int %0d required 0 0", n_done, n_int); end
    endtask

    task automatic test_tfr_error();
        mem.delete();
        mem[64'h6100] = mk(2'b10, 1'b1, 1'b0, 1'b1, 16'h0010, 64'hE000);
        mem[64'h610C] = mk(2'b10, 1'b1, 1'b1, 1'b1, 16'h0020, 64'hF000);
        model_walk(64'h6100, 1);
        run_dma(64'h6100, 1, 1'b1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL tfrerr_timeout: busy %b required 0", busy); end
        checks++; if (n_err != 1) begin errors++; $display("FAIL tfrerr_err: got %0d required 1", n_err); end
        checks++; if (adma_err_state !== 2'b11) begin errors++; $display("FAIL tfrerr_err_state: got %b required 11", adma_err_state); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL tfrerr_done: got %0d required 0", n_done); end
        checks++; if (n_int != exp_int) begin errors++; $display("FAIL tfrerr_int: got %0d required %0d", n_int, exp_int); end
        checks++; if (desc_ptr !== 64'h610C) begin errors++; $display("FAIL tfrerr_ptr: got %h required 610c", desc_ptr); end
    endtask

    task automatic test_abort();
        int d;
        mem.delete();
        mem[64'h6000] = mk(2'b10, 1'b1, 1'b1, 1'b0, 16'h0008, 64'h1234);
        start_dma(64'h6000);
        checks++; if (fetch_start !== 1'b1 || fetch_address !== 64'h6000) begin
            errors++; $display("FAIL abort_fetch_req: start %b addr %h required 1 6000", fetch_start, fetch_address); end
        @(negedge CLK);
        adma_abort = 1'b1;
        fetch_done = 1'b1;
        descriptor = 96'h0;
        #1;
        checks++; if (adma_err || adma_done || adma_int) begin
            errors++; $display("FAIL abort_pulses: err %b done %b int %b required 0 0 0", adma_err, adma_done, adma_int); end
        @(negedge CLK);
        fetch_done = 1'b0;
        checks++; if (fetch_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_stop: fetch_start %b busy %b required 0 0", fetch_start, busy); end
        checks++; if (desc_ptr !== 64'h6000) begin errors++; $display("FAIL abort_ptr: got %h required 6000", desc_ptr); end
        checks++; if (adma_err_state !== 2'b00) begin errors++; $display("FAIL abort_err_state: got %b required 00", adma_err_state); end
        adma_abort = 1'b0;
        mem[64'h5000] = mk(2'b10, 1'b1, 1'b1, 1'b1, 16'h0010, 64'hB000);
        model_walk(64'h5000, -1);
        run_dma(64'h5000, -1, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout: busy %b required 0", busy); end
        checks++; d = qdiff(obs_fetch_q, exp_fetch_q);
        if (d != -1) begin errors++; $display("FAIL restart_fetch[%0d]: got %h required %h", d, qat(obs_fetch_q, d), qat(exp_fetch_q, d)); end
        checks++; d = qdiff(obs_tfr_q, exp_tfr_q);
        if (d != -1) begin errors++; $display("FAIL restart_tfr[%0d]: got %h required %h", d, qat(obs_tfr_q, d), qat(exp_tfr_q, d)); end
        checks++; if (n_done != 1 || n_int != 1) begin errors++; $display("FAIL restart_pulses: done %0d int %0d required 1 1", n_done, n_int); end
    endtask

    task automatic test_random();
        int          d, n, err_at;
        logic [63:0] base, ptr, tgt;
        logic [1:0]  act;
        for (int it = 0; it < 10; it++) begin
            mem.delete();
            base = (it == 0) ? 64'hFFFF_FFFF_FFFF_FFF4
                             : {32'h0, 16'($urandom_range(1, 60000)), 16'h0} + 64'(4 * $urandom_range(0, 100));
            ptr = base;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                act = (it == 0 && k == 0) ? 2'b00 : 2'($urandom_range(0, 3));
                tgt = base + 64'h0100_0000 * 64'(k + 1);
                mem[ptr] = mk(act, ($urandom_range(0, 9) != 0), (k == n - 1), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), tgt);
                ptr = (act == 2'b11) ? tgt : ptr + 64'd12;
            end
            err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
            model_walk(base, err_at);
            run_dma(base, err_at, 1'($urandom_range(0, 1)), 1'b1);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: busy %b required 0", it, busy); end
            checks++; d = qdiff(obs_fetch_q, exp_fetch_q);
            if (d != -1) begin errors++; $display("FAIL rand%0d_fetch[%0d]: got %h required %h", it, d, qat(obs_fetch_q, d), qat(exp_fetch_q, d)); end
            checks++; d = qdiff(obs_tfr_q, exp_tfr_q);
            if (d != -1) begin errors++; $display("FAIL rand%0d_tfr[%0d]: got %h required %h", it, d, qat(obs_tfr_q, d), qat(exp_tfr_q, d)); end
            checks++; if (n_int != exp_int || n_done != exp_done || n_err != exp_err) begin
                errors++; $display("FAIL rand%0d_pulses: int/done/err %0d/%0d/%0d required %0d/%0d/%0d",
                                   it, n_int, n_done, n_err, exp_int, exp_done, exp_err); end
            checks++; if (adma_err_state !== exp_err_state) begin
                errors++; $display("FAIL rand%0d_err_state: got %b required %b", it, adma_err_state, exp_err_state); end
            checks++; if (desc_ptr !== exp_ptr) begin errors++; $display("FAIL rand%0d_ptr: got %h required %h", it, desc_ptr, exp_ptr); end
        end
    endtask

    initial begin
        RESET_N = 1'b0; adma_start = 1'b0; adma_sys_addr = '0; adma_abort = 1'b0;
        fetch_done = 1'b0; descriptor = '0; tfr_done = 1'b0; tfr_error = 1'b0;
        repeat (3) @(posedge CLK);
        test_reset();
        test_tran_chain();
        test_link_nop();
        test_invalid();
        test_tfr_error();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
